// File: rtl/m_stage_mem.sv
// rtl/m_stage_mem.sv - MIPS memory stage: load/store against word-organised data memory, M->W pipeline register
module m_stage_mem #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] ALUout_M,
  input  logic [31:0] rt_M,
  input  logic [4:0]  RDst_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC4_W,
  output logic [31:0] PC8_W,
  output logic [31:0] ALUout_W,
  output logic [31:0] DMout_W,
  output logic [4:0]  RDst_W,
  output logic        misalign_M
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  logic [31:0] mem [DEPTH];

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        offset;
  logic              is_load;
  logic              is_store;
  logic [1:0]        acc_size;   // 0 byte, 1 halfword, 2 word
  logic              sign_ext;
  logic [3:0]        byte_en;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  assign opcode   = IR_M[31:26];
  assign word_idx = ALUout_M[ADDR_W+1:2];
  assign offset   = ALUout_M[1:0];
  assign rd_word  = mem[word_idx];

  // Opcode decode into access class, width and extension mode
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_size = 2'd0;
    sign_ext = 1'b0;
    case (opcode)
      OP_LW:  begin is_load  = 1'b1; acc_size = 2'd2; end
      OP_LB:  begin is_load  = 1'b1; acc_size = 2'd0; sign_ext = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; acc_size = 2'd0; end
      OP_LH:  begin is_load  = 1'b1; acc_size = 2'd1; sign_ext = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; acc_size = 2'd1; end
      OP_SW:  begin is_store = 1'b1; acc_size = 2'd2; end
      OP_SB:  begin is_store = 1'b1; acc_size = 2'd0; end
      OP_SH:  begin is_store = 1'b1; acc_size = 2'd1; end
      default: ;
    endcase
  end

  // Alignment check; independent of reset so the hazard logic always sees it
  always_comb begin
    misalign_M = 1'b0;
    if (is_load || is_store) begin
      case (acc_size)
        2'd2:    misalign_M = (offset != 2'b00);
        2'd1:    misalign_M = offset[0];
        default: misalign_M = 1'b0;
      endcase
    end
  end

  // Store lane enables and replicated write data so any lane can pick its byte
  always_comb begin
    byte_en = 4'b0000;
    wdata   = rt_M;
    case (acc_size)
      2'd2: byte_en = 4'b1111;
      2'd1: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wdata   = {rt_M[15:0], rt_M[15:0]};
      end
      default: begin
        byte_en = 4'b0001 << offset;
        wdata   = {4{rt_M[7:0]}};
      end
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    case (offset)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (acc_size)
      2'd2:    load_data = rd_word;
      2'd1:    load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
      default: load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
    endcase
  end

  // Data memory: full clear on reset, byte-enabled write for aligned stores
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= 32'd0;
      end
    end else if (is_store && !misalign_M) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // M->W pipeline register; misaligned loads drop their result and destination
  always_ff @(posedge clk) begin
    if (reset) begin
      IR_W     <= 32'd0;
      PC4_W    <= 32'd0;
      PC8_W    <= 32'd0;
      ALUout_W <= 32'd0;
      DMout_W  <= 32'd0;
      RDst_W   <= 5'd0;
    end else begin
      IR_W     <= IR_M;
      PC4_W    <= PC4_M;
      PC8_W    <= PC8_M;
      ALUout_W <= ALUout_M;
      DMout_W  <= (is_load && !misalign_M) ? load_data : 32'd0;
      RDst_W   <= (is_load && misalign_M) ? 5'd0 : RDst_M;
    end
  end

endmodule

// File: tb/tb_m_stage_mem.sv
// tb/tb_m_stage_mem.sv - directed-vector bench for m_stage_mem
module tb_m_stage_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_M, PC4_M, PC8_M, ALUout_M, rt_M;
  logic [4:0]  RDst_M;
  logic [31:0] IR_W, PC4_W, PC8_W, ALUout_W, DMout_W;
  logic [4:0]  RDst_W;
  logic        misalign_M;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] pc = 32'h0000_0100;

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;

  m_stage_mem #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .IR_M(IR_M), .PC4_M(PC4_M), .PC8_M(PC8_M), .ALUout_M(ALUout_M),
    .rt_M(rt_M), .RDst_M(RDst_M),
    .IR_W(IR_W), .PC4_W(PC4_W), .PC8_W(PC8_W), .ALUout_W(ALUout_W),
    .DMout_W(DMout_W), .RDst_W(RDst_W), .misalign_M(misalign_M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one instruction at the falling edge, then let it retire at the next rising edge
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [4:0] rd);
    @(negedge clk);
    IR_M     = {op, 26'd0};
    ALUout_M = addr;
    rt_M     = rt;
    RDst_M   = rd;
    PC4_M    = pc + 32'd4;
    PC8_M    = pc + 32'd8;
    pc       = pc + 32'd4;
    #1;
  endtask

  task automatic retire;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    IR_M = '0; PC4_M = '0; PC8_M = '0; ALUout_M = '0; rt_M = '0; RDst_M = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_IR_W", IR_W, 32'd0);
    check("rst_PC4_W", PC4_W, 32'd0);
    check("rst_PC8_W", PC8_W, 32'd0);
    check("rst_ALUout_W", ALUout_W, 32'd0);
    check("rst_DMout_W", DMout_W, 32'd0);
    check("rst_RDst_W", {27'd0, RDst_W}, 32'd0);
    check("rst_misalign", {31'd0, misalign_M}, 32'd0);
    reset = 1'b0;

    issue(LW, 32'h10, 32'h0, 5'd5); retire;
    check("lw_after_reset", DMout_W, 32'd0);
    check("lw_rdst", {27'd0, RDst_W}, 32'd5);

    issue(SW, 32'h20, 32'h1234_5678, 5'd0); retire;
    issue(LW, 32'h20, 32'h0, 5'd2); retire;
    check("sw_lw_raw", DMout_W, 32'h1234_5678);
    check("lw_pc4", PC4_W, pc + 32'd0);
    check("lw_pc8", PC8_W, pc + 32'd4);
    issue(LBU, 32'h23, 32'h0, 5'd2); retire;
    check("lbu_23", DMout_W, 32'h0000_0012);
    issue(LB, 32'h21, 32'h0, 5'd2); retire;
    check("lb_21", DMout_W, 32'h0000_0056);

    issue(SB, 32'h22, 32'hFFFF_FF80, 5'd0); retire;
    issue(LW, 32'h20, 32'h0, 5'd3); retire;
    check("sb_lane2", DMout_W, 32'h1280_5678);
    issue(LB, 32'h22, 32'h0, 5'd3); retire;
    check("lb_signext", DMout_W, 32'hFFFF_FF80);

    issue(SH, 32'h20, 32'h0000_8001, 5'd0); retire;
    issue(LHU, 32'h20, 32'h0, 5'd4); retire;
    check("lhu_20", DMout_W, 32'h0000_8001);
    issue(LH, 32'h20, 32'h0, 5'd4); retire;
    check("lh_20", DMout_W, 32'hFFFF_8001);
    issue(LW, 32'h20, 32'h0, 5'd4); retire;
    check("sh_low_half", DMout_W, 32'h1280_8001);

    issue(SW, 32'h21, 32'hCAFE_BABE, 5'd0);
    check("sw_mis_flag", {31'd0, misalign_M}, 32'd1);
    retire;
    issue(LW, 32'h20, 32'h0, 5'd6); retire;
    check("sw_mis_nowrite", DMout_W, 32'h1280_8001);

    issue(LH, 32'h23, 32'h0, 5'd9);
    check("lh_mis_flag", {31'd0, misalign_M}, 32'd1);
    retire;
    check("lh_mis_dm", DMout_W, 32'd0);
    check("lh_mis_rdst", {27'd0, RDst_W}, 32'd0);
    issue(LB, 32'h23, 32'h0, 5'd9);
    check("lb_23_aligned", {31'd0, misalign_M}, 32'd0);
    retire;
    check("lb_23_data", DMout_W, 32'h0000_0012);
    check("lb_23_rdst", {27'd0, RDst_W}, 32'd9);

    issue(SW, 32'h0000_4004, 32'hDEAD_BEEF, 5'd0); retire;
    issue(LW, 32'h0000_0004, 32'h0, 5'd7); retire;
    check("wrap_lw", DMout_W, 32'hDEAD_BEEF);

    @(negedge clk);
    IR_M = 32'h0109_4021; ALUout_M = 32'h55; rt_M = 32'hFFFF_FFFF; RDst_M = 5'd8;
    #1;
    check("addu_mis", {31'd0, misalign_M}, 32'd0);
    retire;
    check("addu_ALUout", ALUout_W, 32'h55);
    check("addu_RDst", {27'd0, RDst_W}, 32'd8);
    check("addu_DMout", DMout_W, 32'd0);
    check("addu_IR", IR_W, 32'h0109_4021);
    issue(LW, 32'h54, 32'h0, 5'd1); retire;
    check("addu_nomem", DMout_W, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    IR_M = {SW, 26'd0}; ALUout_M = 32'h40; rt_M = 32'hAAAA_AAAA; RDst_M = 5'd3;
    retire;
    check("midrst_ALUout", ALUout_W, 32'd0);
    check("midrst_IR", IR_W, 32'd0);
    reset = 1'b0;
    issue(LW, 32'h40, 32'h0, 5'd1); retire;
    check("midrst_nostore", DMout_W, 32'd0);
    issue(LW, 32'h20, 32'h0, 5'd1); retire;
    check("midrst_memclr", DMout_W, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
